// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
// Shared definitions for the multiplexed 4-digit 7-segment display scheduler.
// Holds:
//   SEG_BLANK / AN_OFF  - all-off patterns for the active-low segment and
//                         anode buses
//   disp_state_e        - scan FSM states (IDLE, BLANK, DRIVE)
//   CHAR_*              - active-low glyphs that requesters place in their
//                         frames, bit order {g,f,e,d,c,b,a}
//   digit_anode()       - anode pattern for a scan position (0 = leftmost)
// ---------------------------------------------------------------------------
package seg_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } disp_state_e;

  // Active-low glyphs, bit 6 = segment g ... bit 0 = segment a.
  localparam logic [6:0] CHAR_A = 7'h08;
  localparam logic [6:0] CHAR_C = 7'h46;
  localparam logic [6:0] CHAR_E = 7'h06;
  localparam logic [6:0] CHAR_H = 7'h09;
  localparam logic [6:0] CHAR_L = 7'h47;
  localparam logic [6:0] CHAR_O = 7'h40;
  localparam logic [6:0] CHAR_P = 7'h0C;
  localparam logic [6:0] CHAR_U = 7'h41;
  localparam logic [6:0] CHAR_V = 7'h63;

  // Scan position 0 drives an[3] (leftmost), position 3 drives an[0].
  function automatic logic [3:0] digit_anode(input logic [1:0] pos);
    return ~(4'b1000 >> pos);
  endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// ---------------------------------------------------------------------------
// seg_rr_arbiter
// Purely combinational round-robin pick. The search begins at rr_ptr and
// wraps from NUM_REQ-1 back to 0; the first requesting index wins. The
// pointer register itself lives in the parent.
// Ports:
//   req      [NUM_REQ-1:0]  requester levels
//   rr_ptr   [IW-1:0]       first index to examine (one past the last owner)
//   update   1              evaluate a new grant; output is zero otherwise
//   gnt_next [NUM_REQ-1:0]  one-hot winner, zero if nobody requests
// ---------------------------------------------------------------------------
module seg_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt_next
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_next = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IW'((32'(rr_ptr) + 32'(off)) % NUM_REQ);
      if (update && !found && req[idx]) begin
        gnt_next[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// ---------------------------------------------------------------------------
// seg_display_scheduler
// Shares one 4-digit multiplexed 7-segment display among NUM_REQ requesters.
// Each scan_tick inserts a one-cycle anti-ghost BLANK, then lights the next
// digit (an[3] -> an[0]). Ownership is re-evaluated only at frame boundaries
// (end of digit an[0], or any tick while idle); the owner's 28-bit frame is
// snapshotted there so mid-frame edits never tear the display.
// An owner keeps the grant while it requests, until it has shown HOLD_FRAMES
// frames and someone else is waiting; then round-robin moves on.
//
// Optional feature: define SEG_BLINK_EN to enable per-requester blinking
// (phase toggles every 32 frames; blinking owners show blank segments in the
// off phase while the anodes keep scanning). Without it, blink is ignored.
//
// Ports:
//   basys_clock  in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   scan_tick    in   single-cycle digit-advance strobe
//   req          in   [NUM_REQ-1:0] level requests
//   frame        in   [NUM_REQ*28-1:0] 4 x 7 active-low segments per requester,
//                     bits [27:21] of each slice are the leftmost digit
//   blink        in   [NUM_REQ-1:0] per-requester blink enable
//   an           out  [3:0] active-low anodes, an[3] leftmost
//   seg          out  [6:0] active-low segments
//   gnt          out  [NUM_REQ-1:0] one-hot owner, zero when idle
// ---------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int HOLD_FRAMES = 8,
  parameter int NUM_REQ     = 3
) (
  input  logic                   basys_clock,
  input  logic                   rst_n,
  input  logic                   scan_tick,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*28-1:0]  frame,
  input  logic [NUM_REQ-1:0]     blink,
  output logic [3:0]             an,
  output logic [6:0]             seg,
  output logic [NUM_REQ-1:0]     gnt
);

  import seg_disp_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  disp_state_e        state_q, state_d;
  logic [1:0]         digit_q, digit_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [27:0]        snap_q, snap_d;

  logic [27:0]        frame_arr [NUM_REQ];
  logic               boundary;
  logic               owner_req;
  logic               others_req;
  logic [HW-1:0]      hold_inc;
  logic               keep;
  logic               arb_update;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] sel_gnt;
  logic [IW-1:0]      sel_idx;
  logic [6:0]         cur_digit;
  logic               digit_dark;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frame
    assign frame_arr[gi] = frame[gi*28 +: 28];
  end

  // Frame boundary: tick at the end of the rightmost digit, or any tick
  // while idle. Ticks during BLANK are ignored by construction.
  assign boundary   = scan_tick &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_DRIVE) && (digit_q == 2'd3)));
  assign owner_req  = |(gnt_q & req);
  assign others_req = |(req & ~gnt_q);
  // hold_inc counts the frame just completed; saturates so a sole requester
  // never wraps the counter.
  assign hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
  assign keep       = owner_req && !((hold_inc >= HOLD_MAX) && others_req);
  assign arb_update = boundary && !keep;
  assign sel_gnt    = keep ? gnt_q : arb_gnt;

  seg_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req      (req),
    .rr_ptr   (ptr_q),
    .update   (arb_update),
    .gnt_next (arb_gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_gnt[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE, ST_DRIVE: begin
        if (boundary) begin
          gnt_d   = sel_gnt;
          hold_d  = keep ? hold_inc : '0;
          digit_d = 2'd0;
          if (!keep && (|arb_gnt)) begin
            ptr_d = (sel_idx == IW'(NUM_REQ - 1)) ? '0 : sel_idx + IW'(1);
          end
          if (|sel_gnt) begin
            state_d = ST_BLANK;
            snap_d  = frame_arr[sel_idx];
          end else begin
            state_d = ST_IDLE;
            snap_d  = {4{SEG_BLANK}};
          end
        end else if (scan_tick) begin
          state_d = ST_BLANK;
          digit_d = digit_q + 2'd1;
        end
      end
      ST_BLANK: state_d = ST_DRIVE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      digit_q <= 2'd0;
      gnt_q   <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      snap_q  <= {4{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
    end
  end

`ifdef SEG_BLINK_EN
  // Free-running frame count; phase 0 is the off phase. The off decision is
  // latched per frame so it cannot change in the middle of a scan.
  logic [4:0] blink_cnt_q;
  logic       blink_phase_q;
  logic       blink_off_q;

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= 5'd0;
      blink_phase_q <= 1'b0;
      blink_off_q   <= 1'b0;
    end else if (boundary) begin
      blink_cnt_q <= blink_cnt_q + 5'd1;
      if (blink_cnt_q == 5'd31) blink_phase_q <= ~blink_phase_q;
      blink_off_q <= ~blink_phase_q & (|(sel_gnt & blink));
    end
  end

  assign digit_dark = blink_off_q;
`else
  logic unused_blink;
  assign unused_blink = ^blink;
  assign digit_dark   = 1'b0;
`endif

  always_comb begin
    case (digit_q)
      2'd0:    cur_digit = snap_q[27:21];
      2'd1:    cur_digit = snap_q[20:14];
      2'd2:    cur_digit = snap_q[13:7];
      default: cur_digit = snap_q[6:0];
    endcase
  end

  // Outputs decode straight from the asynchronously reset registers, so
  // asserting rst_n blanks the display without waiting for a clock.
  always_comb begin
    an  = AN_OFF;
    seg = SEG_BLANK;
    if (state_q == ST_DRIVE) begin
      an  = digit_anode(digit_q);
      seg = digit_dark ? SEG_BLANK : cur_digit;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: doc/seg_display_scheduler.md
SEG_DISPLAY_SCHEDULER -- requirements
Module: seg_display_scheduler

Interface
REQ-001 Parameter HOLD_FRAMES, default 8: minimum whole frames a grant is held while another requester is pending.
REQ-002 Parameter NUM_REQ, default 3: number of display requesters.
REQ-003 Port basys_clock, input, 1 bit: the single system clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port scan_tick, input, 1 bit: single-cycle digit-advance strobe at about 1.5 kHz, with at least 2 cycles between strobes.
REQ-006 Port req, input, NUM_REQ bits: per-requester display request, level-sensitive.
REQ-007 Port frame, input, NUM_REQ*28 bits: per-requester 4 digits x 7 active-low segments; bits [27:21] are the leftmost digit.
REQ-008 Port blink, input, NUM_REQ bits: per-requester blink enable, used only with SEG_BLINK_EN.
REQ-009 Port an, output, 4 bits: active-low anodes; an[3] is the leftmost digit.
REQ-010 Port seg, output, 7 bits: active-low segments.
REQ-011 Port gnt, output, NUM_REQ bits: one-hot current owner; all zero when idle.

Function
REQ-012 The FSM SHALL have states IDLE, BLANK and DRIVE.
- IDLE: an=4'hF, seg=7'h7F.
- BLANK: one-cycle anti-ghost gap; an=4'hF.
- DRIVE: the selected digit is lit.
REQ-013 Each scan_tick SHALL move the FSM to BLANK for exactly one cycle, then to DRIVE for the next digit, in scan order an[3], an[2], an[1], an[0].
REQ-014 A frame SHALL be the four digits of one scan; the frame boundary is the scan_tick that ends digit an[0], or any scan_tick while in IDLE.
REQ-015 At each frame boundary the block SHALL snapshot the owner's frame into an internal register; mid-frame changes to frame and req SHALL NOT alter the frame being shown.
REQ-016 Grant changes SHALL occur only at frame boundaries; the new gnt SHALL appear in the BLANK cycle that follows the boundary.
REQ-017 Arbitration SHALL be round-robin, searching from owner+1 and wrapping from NUM_REQ-1 to 0; after reset the search starts at index 0.
REQ-018 An owner that still requests SHALL keep the grant until a saturating frame counter reaches HOLD_FRAMES with another request pending.
REQ-019 An owner that drops req, at any point in a frame, SHALL finish the snapshotted frame and then yield, or go to IDLE if no request is pending.
REQ-020 With a sole requester the grant SHALL be held indefinitely, and the hold counter SHALL saturate rather than wrap.
REQ-021 When a new requester is granted from IDLE, scanning SHALL start at an[3].
REQ-022 A scan_tick that arrives during BLANK SHALL be ignored.
REQ-023 req bits that rise and fall entirely within one frame SHALL NOT be granted.

Reset
REQ-024 While rst_n=0, outputs SHALL be an=4'hF, seg=7'h7F, gnt=0.
REQ-025 While rst_n=0, internal state SHALL be: state IDLE, digit pointer at an[3], hold counter 0, round-robin pointer 0, snapshot all 7'h7F.
REQ-026 Reset asserted mid-frame SHALL blank the display immediately, asynchronously and without waiting for a clock edge.
REQ-027 The first scan_tick after reset release SHALL be treated as a frame boundary.

Configuration
REQ-028 With SEG_BLINK_EN defined, a free-running frame counter SHALL toggle a blink phase every 32 frames.
REQ-029 With SEG_BLINK_EN defined, digits of an owner whose blink bit is 1 SHALL drive seg=7'h7F during the off phase, with the anode scan unchanged.
REQ-030 With SEG_BLINK_EN undefined, the blink input SHALL be ignored, and the blink counter and phase logic SHALL NOT be present.

Structure
REQ-031 Shared package seg_disp_pkg SHALL hold:
- SEG_BLANK=7'h7F and AN_OFF=4'hF;
- the FSM state enum;
- the 7-segment character constants (CHAR_A..CHAR_V) used by requesters.
REQ-032 Round-robin selection SHALL be one sub-module, seg_rr_arbiter, with inputs req, owner and an update strobe, and output next one-hot grant; it is purely combinational, with the pointer register kept in the parent.

Verification
REQ-033 Reset then req=3'b001 with frame0 holding chars H,E,L,L, four scan_ticks -> gnt=001; an sequence 0111,1011,1101,1110, each preceded by a single 1111 cycle; seg matches each char.
REQ-034 req=3'b011 held, HOLD_FRAMES=8 -> gnt alternates 001 and 010 every 8 frames; no gnt change occurs except in the BLANK cycle after a boundary.
REQ-035 frame0 changed after digit an[2] is lit -> an[1] and an[0] still show the old data; the new data appears from the next frame.
REQ-036 Owner 0 drops req mid-frame while req2=1 -> the frame completes, then gnt=100; with no requester pending -> IDLE, an=4'hF, seg=7'h7F.
REQ-037 rst_n asserted mid-DRIVE -> same cycle an=4'hF, gnt=0; after release the first scan_tick lights an[3].
REQ-038 With SEG_BLINK_EN defined and blink0=1 -> seg=7'h7F for 32 frames, then data for 32 frames, with anodes still scanning; with SEG_BLINK_EN undefined, seg always shows data.
